sqrt_seq_param: RTL and testbench

- Parametrised, handshaked integer square-root unit; next generation of the team's 16-bit sqrt block.
- Computes floor(sqrt(valor)) for an unsigned WIDTH-bit operand using the digit-by-digit (restoring) method, one result bit per clock.
- Adds a start/ready handshake, a busy flag, a held result and an optional remainder output.
- Sits behind the command-driven bench driver and is reused by datapath blocks needing magnitude roots.

---
 rtl/sqrt_seq_param_if.sv | 75 +++++++
 rtl/sqrt_seq_param.sv | 173 +++++++++++++++++
 tb/tb_sqrt_seq_param.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sqrt_seq_param_if.sv
// ---------------------------------------------------------------------------
// sqrt_seq_param_if
// Handshake/result bundle for the sequential integer square-root unit.
//
// Parameter:
//   WIDTH      radicand width in bits (even, >= 4); result width RW = WIDTH/2
//
// Signals:
//   start      request from the requester, honoured only while ready=1
//   valor      unsigned WIDTH-bit radicand, sampled on the accepting edge
//   ready      unit idle and able to accept a request
//   busy       unit iterating
//   endop      one-cycle completion pulse
//   sqrt       floor square root, held until the next completion
//   remainder  valor - sqrt^2 (RW+1 bits), only when SQRT_REMAINDER_EN is defined
//
// Modports:
//   master     requester side (drives start/valor)
//   slave      square-root unit side (drives status and results)
//
// Optional feature macro: SQRT_REMAINDER_EN
// ---------------------------------------------------------------------------
interface sqrt_seq_param_if #(
    parameter int WIDTH = 16
);
    localparam int RW = WIDTH / 2;

    logic             start;
    logic [WIDTH-1:0] valor;
    logic             ready;
    logic             busy;
    logic             endop;
    logic [RW-1:0]    sqrt;
`ifdef SQRT_REMAINDER_EN
    logic [RW:0]      remainder;

    modport master (
        output start,
        output valor,
        input  ready,
        input  busy,
        input  endop,
        input  sqrt,
        input  remainder
    );

    modport slave (
        input  start,
        input  valor,
        output ready,
        output busy,
        output endop,
        output sqrt,
        output remainder
    );
`else
    modport master (
        output start,
        output valor,
        input  ready,
        input  busy,
        input  endop,
        input  sqrt
    );

    modport slave (
        input  start,
        input  valor,
        output ready,
        output busy,
        output endop,
        output sqrt
    );
`endif
endinterface

// File: rtl/sqrt_seq_param.sv
// ---------------------------------------------------------------------------
// sqrt_seq_param
// Sequential integer square root: floor(sqrt(valor)) of an unsigned WIDTH-bit
// radicand using the restoring digit-by-digit method, one result bit per clock.
//
// Parameter:
//   WIDTH   radicand width (even, >= 4), must match the connected interface
//
// Ports:
//   clock   system clock, rising edge
//   reset   synchronous active-high reset (aborts any running operation)
//   bus     sqrt_seq_param_if.slave: start/valor in, ready/busy/endop/sqrt
//           (and remainder) out
//
// Timing: request accepted at edge k, iterations on edges k+1..k+RW, endop and
// the new result visible after edge k+RW, ready again after edge k+RW+1.
// All outputs come straight from registers.
//
// Optional feature macro: SQRT_REMAINDER_EN -- adds the registered remainder
// output. Without it the partial remainder is only used internally.
// ---------------------------------------------------------------------------
module sqrt_seq_param #(
    parameter int WIDTH = 16
) (
    input  logic           clock,
    input  logic           reset,
    sqrt_seq_param_if.slave bus
);
    localparam int RW = WIDTH / 2;
    localparam int CW = $clog2(RW + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state_r;
    logic [1:0]       state_nx_s;
    logic [WIDTH-1:0] shift_r;
    logic [RW-1:0]    root_r;
    logic [RW+1:0]    rem_r;
    logic [CW-1:0]    count_r;
    logic [RW-1:0]    sqrt_r;
    logic             ready_r;
    logic             busy_r;
    logic             endop_r;

    logic [RW+1:0]    r_s;
    logic [RW+1:0]    t_s;
    logic [RW+1:0]    rem_nx_s;
    logic [RW-1:0]    root_nx_s;
    logic             last_s;

    // One restoring iteration on the current partial root/remainder.
    always_comb begin
        r_s       = {rem_r[RW-1:0], shift_r[WIDTH-1 -: 2]};
        t_s       = {root_r, 2'b01};
        rem_nx_s  = r_s;
        root_nx_s = {root_r[RW-2:0], 1'b0};
        // The top two remainder bits are always zero in legal operation
        // (rem <= 2*root); if either were set the true shifted value would
        // exceed any trial value, so they force the subtract path.
        if ((rem_r[RW+1:RW] != 2'b00) || (r_s >= t_s)) begin
            rem_nx_s  = r_s - t_s;
            root_nx_s = {root_r[RW-2:0], 1'b1};
        end else begin
            rem_nx_s  = r_s;
            root_nx_s = {root_r[RW-2:0], 1'b0};
        end
    end

    // Final iteration is the one that takes the counter from 1 to 0.
    always_comb begin
        last_s = 1'b0;
        if (count_r == CW'(1)) begin
            last_s = 1'b1;
        end else begin
            last_s = 1'b0;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nx_s = ST_CALC;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (last_s) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_CALC;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // State register and status flags, registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r <= ST_IDLE;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            endop_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            ready_r <= (state_nx_s == ST_IDLE);
            busy_r  <= (state_nx_s == ST_CALC);
            endop_r <= (state_nx_s == ST_DONE);
        end
    end

    // Iteration datapath and held root result.
    always_ff @(posedge clock) begin
        if (reset) begin
            shift_r <= '0;
            root_r  <= '0;
            rem_r   <= '0;
            count_r <= '0;
            sqrt_r  <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        shift_r <= bus.valor;
                        root_r  <= '0;
                        rem_r   <= '0;
                        count_r <= CW'(RW);
                    end
                end
                ST_CALC: begin
                    shift_r <= {shift_r[WIDTH-3:0], 2'b00};
                    root_r  <= root_nx_s;
                    rem_r   <= rem_nx_s;
                    count_r <= count_r - CW'(1);
                    if (last_s) begin
                        sqrt_r <= root_nx_s;
                    end
                end
                default: begin
                    shift_r <= shift_r;
                end
            endcase
        end
    end

`ifdef SQRT_REMAINDER_EN
    logic [RW:0] remainder_r;

    // Held remainder result, written on the completion edge only.
    always_ff @(posedge clock) begin
        if (reset) begin
            remainder_r <= '0;
        end else if ((state_r == ST_CALC) && last_s) begin
            remainder_r <= rem_nx_s[RW:0];
        end
    end

    assign bus.remainder = remainder_r;
`endif

    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;
    assign bus.endop = endop_r;
    assign bus.sqrt  = sqrt_r;

endmodule

// File: tb/tb_sqrt_seq_param.sv
// ---------------------------------------------------------------------------
// tb_sqrt_seq_param
// Self-checking bench for sqrt_seq_param at WIDTH=16 and WIDTH=32. Expected
// roots come from a binary-search floor(sqrt) reference; remainders are
// x - s*s. Remainder checks are compiled in with SQRT_REMAINDER_EN.
// ---------------------------------------------------------------------------
module tb_sqrt_seq_param;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst16;
    logic rst32;

    sqrt_seq_param_if #(.WIDTH(16)) if16 ();
    sqrt_seq_param_if #(.WIDTH(32)) if32 ();

    sqrt_seq_param #(.WIDTH(16)) u16 (.clock(clk), .reset(rst16), .bus(if16.slave));
    sqrt_seq_param #(.WIDTH(32)) u32 (.clock(clk), .reset(rst32), .bus(if32.slave));

    // sel=0 drives/observes the 16-bit unit, sel=1 the 32-bit unit
    logic        sel;
    logic        d_start;
    logic [31:0] d_valor;

    assign if16.start = sel ? 1'b0 : d_start;
    assign if16.valor = d_valor[15:0];
    assign if32.start = sel ? d_start : 1'b0;
    assign if32.valor = d_valor;

    logic        m_ready;
    logic        m_busy;
    logic        m_endop;
    logic [31:0] m_sqrt;
    assign m_ready = sel ? if32.ready : if16.ready;
    assign m_busy  = sel ? if32.busy  : if16.busy;
    assign m_endop = sel ? if32.endop : if16.endop;
    assign m_sqrt  = sel ? {16'h0000, if32.sqrt} : {24'h000000, if16.sqrt};
`ifdef SQRT_REMAINDER_EN
    logic [31:0] m_rem;
    assign m_rem = sel ? {15'h0000, if32.remainder} : {23'h000000, if16.remainder};
`endif

    int n_checks = 0;
    int n_pass   = 0;
    longint last_exp [2];

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // floor(sqrt(x)) for 0 <= x < 2^32 by binary search
    function automatic longint isqrt(input longint x);
        longint lo = 0;
        longint hi = 65536;
        longint mid;
        while (hi - lo > 1) begin
            mid = (lo + hi) / 2;
            if (mid * mid <= x) lo = mid;
            else hi = mid;
        end
        return lo;
    endfunction

    task automatic wait_ready();
        int n = 0;
        while (!m_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait", m_ready, 1);
    endtask

    // One full operation; poke=1 pulses start with another valor mid-CALC
    task automatic op(input bit w32, input longint v, input bit poke);
        int rw;
        int lat;
        int busy_cnt;
        int bad;
        bit got;
        longint es;
        longint er;
        rw = w32 ? 16 : 8;
        es = isqrt(v);
        er = v - es * es;
        @(negedge clk);
        sel = w32;
        d_start = 1'b0;
        wait_ready();
        d_start = 1'b1;
        d_valor = v[31:0];
        @(posedge clk);
        #1;
        d_start = 1'b0;
        d_valor = $urandom;
        busy_cnt = m_busy;
        lat = 0;
        got = 1'b0;
        bad = 0;
        for (int i = 0; i < 3 * rw && !got; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (poke && lat == 2) begin
                d_start = 1'b1;
                d_valor = $urandom;
            end
            if (poke && lat == 3) d_start = 1'b0;
            if (m_endop) begin
                got = 1'b1;
            end else begin
                busy_cnt += m_busy;
                if (m_sqrt != last_exp[w32]) bad++;
            end
        end
        d_start = 1'b0;
        check("endop_seen", got, 1);
        check("latency", lat, rw);
        check("busy_cycles", busy_cnt, rw);
        check("sqrt", m_sqrt, es);
`ifdef SQRT_REMAINDER_EN
        check("remainder", m_rem, er);
`endif
        check("held_before_endop", bad, 0);
        check("busy_at_done", m_busy, 0);
        check("ready_at_done", m_ready, 0);
        @(posedge clk);
        #1;
        check("endop_one_cycle", m_endop, 0);
        check("ready_back", m_ready, 1);
        check("sqrt_hold", m_sqrt, es);
        last_exp[w32] = es;
    endtask

    longint res [2];
    longint rems [2];
    int     cyc [2];
    int     n;
    int     extra;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sel = 1'b0;
        d_start = 1'b0;
        d_valor = 32'h0;
        rst16 = 1'b1;
        rst32 = 1'b1;
        last_exp[0] = 0;
        last_exp[1] = 0;
        repeat (2) @(posedge clk);
        #1;
        rst16 = 1'b0;
        rst32 = 1'b0;

        // reset values
        check("rst_ready16", if16.ready, 1);
        check("rst_busy16", if16.busy, 0);
        check("rst_endop16", if16.endop, 0);
        check("rst_sqrt16", if16.sqrt, 0);
        check("rst_ready32", if32.ready, 1);
        check("rst_busy32", if32.busy, 0);
        check("rst_sqrt32", if32.sqrt, 0);
`ifdef SQRT_REMAINDER_EN
        check("rst_rem16", if16.remainder, 0);
        check("rst_rem32", if32.remainder, 0);
`endif

        // directed 16-bit values
        op(1'b0, 4, 1'b0);
        op(1'b0, 65535, 1'b0);
        op(1'b0, 0, 1'b0);
        op(1'b0, 17, 1'b0);

        // start held high: 100 then 200, each taken only when ready
        @(negedge clk);
        sel = 1'b0;
        wait_ready();
        d_start = 1'b1;
        d_valor = 32'd100;
        @(posedge clk);
        #1;
        d_valor = 32'd200;
        n = 0;
        for (int i = 1; i <= 60 && n < 2; i++) begin
            @(posedge clk);
            #1;
            if (m_endop) begin
                res[n] = m_sqrt;
`ifdef SQRT_REMAINDER_EN
                rems[n] = m_rem;
`else
                rems[n] = 0;
`endif
                cyc[n] = i;
                n++;
            end
        end
        d_start = 1'b0;
        check("held_count", n, 2);
        check("held_res0", res[0], 10);
        check("held_res1", res[1], 14);
        check("held_first_lat", cyc[0], 8);
        check("held_spacing", cyc[1] - cyc[0], 10);
`ifdef SQRT_REMAINDER_EN
        check("held_rem0", rems[0], 0);
        check("held_rem1", rems[1], 4);
`endif
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            extra += m_endop;
        end
        check("held_no_extra", extra, 0);
        last_exp[0] = 14;

        // reset during CALC
        @(negedge clk);
        wait_ready();
        d_start = 1'b1;
        d_valor = 32'd10000;
        @(posedge clk);
        #1;
        d_start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst16 = 1'b1;
        @(posedge clk);
        #1;
        check("abort_ready", m_ready, 1);
        check("abort_busy", m_busy, 0);
        check("abort_endop", m_endop, 0);
        check("abort_sqrt", m_sqrt, 0);
        rst16 = 1'b0;
        last_exp[0] = 0;
        extra = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            extra += m_endop;
        end
        check("abort_no_endop", extra, 0);
        op(1'b0, 10000, 1'b0);

        // start pulsed during CALC is ignored
        op(1'b0, 50000, 1'b1);
        op(1'b0, 1, 1'b1);

        // 32-bit directed values
        op(1'b1, 1000000, 1'b0);
        op(1'b1, 64'd4294967295, 1'b0);
        op(1'b1, 0, 1'b0);
        op(1'b1, 64'd4294836225, 1'b1);

        // random sweeps against the reference model
        for (int i = 0; i < 16; i++) begin
            op(1'b0, longint'($urandom_range(0, 65535)), (i % 3) == 0);
        end
        for (int i = 0; i < 16; i++) begin
            op(1'b1, longint'($urandom), (i % 4) == 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
